// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings: opcodes, FSM states and datapath mux selects.
// Used by the main FSM and the instruction decoder. Macro: ILLEGAL_TRAP_EN adds S_TRAP.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_LUI      = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_JALR_ADR = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_BEQ      = 4'd12;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd13;
`endif

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASSB  = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/riscv_main_fsm_out_dec.sv
// Moore output decode for the main FSM: state (+ mem_ready in FETCH) -> controls.
// Ports: i_state (4b), i_mem_ready, o_ctrl (ctrl_t bundle of all control outputs).
module main_fsm_out_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_write   = i_mem_ready;
                o_ctrl.pc_update  = i_mem_ready;
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.result_src = RES_ALURES;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR_ADR: begin
                o_ctrl.alu_src_a = SRCA_RD1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                o_ctrl.result_src = RES_DATA;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                o_ctrl.alu_src_a = SRCA_RD1;
                o_ctrl.alu_src_b = SRCB_RD2;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                o_ctrl.alu_src_a = SRCA_RD1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_PASSB;
            end
            S_ALUWB: begin
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.reg_write  = 1'b1;
            end
            // PC takes the target held in ALUOut while the ALU forms OldPC+4
            S_JAL: begin
                o_ctrl.alu_src_a  = SRCA_OLDPC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.pc_update  = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alu_src_a  = SRCA_RD1;
                o_ctrl.alu_src_b  = SRCB_RD2;
                o_ctrl.alu_op     = ALU_SUB;
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.branch     = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/riscv_main_fsm.sv
// Multicycle main control FSM: state register, next-state logic, reset gating.
// Ports: clk, rst (sync, active-high), op[6:0], mem_ready -> control strobes/selects;
// illegal_instr only when ILLEGAL_TRAP_EN is defined.
module riscv_main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dec_state;
    logic       w_dec_ready;
    ctrl_t      w_ctrl;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] S_BAD_OP = S_TRAP;
`else
    localparam logic [3:0] S_BAD_OP = S_FETCH;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I_ALU:     w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = S_JALR_ADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_LUI:       w_next = S_LUI;
                    OP_AUIPC:     w_next = S_ALUWB;
                    default:      w_next = S_BAD_OP;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JALR_ADR: w_next = S_JAL;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst)                   r_illegal <= 1'b0;
        else if (w_next == S_TRAP) r_illegal <= 1'b1;
    end

    assign illegal_instr = r_illegal;
`endif

    // During reset present FETCH selects with mem_ready masked, so no strobe fires
    assign w_dec_state = rst ? S_FETCH : r_state;
    assign w_dec_ready = mem_ready & ~rst;

    main_fsm_out_dec u_out_dec (
        .i_state     (w_dec_state),
        .i_mem_ready (w_dec_ready),
        .o_ctrl      (w_ctrl)
    );

    assign ir_write   = w_ctrl.ir_write;
    assign pc_update  = w_ctrl.pc_update;
    assign branch     = w_ctrl.branch;
    assign reg_write  = w_ctrl.reg_write;
    assign mem_write  = w_ctrl.mem_write;
    assign adr_src    = w_ctrl.adr_src;
    assign result_src = w_ctrl.result_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_op     = w_ctrl.alu_op;

endmodule

// File: tb/tb_riscv_main_fsm.sv
// Randomized bench for riscv_main_fsm against a per-instruction phase model.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_riscv_main_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b1;
    logic       ir_write, pc_update, branch, reg_write, mem_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    riscv_main_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .branch     (branch),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_instr (illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    logic [13:0] outs;
    assign outs = {ir_write, pc_update, branch, reg_write, mem_write, adr_src,
                   result_src, alu_src_a, alu_src_b, alu_op};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each instruction is a list of named phases
    string      q[$];
    logic [6:0] opq[$];
    logic [6:0] cur_op;
    bit         m_ill = 0;
    int         cur_fw, cur_nfw, done_base, done_nfw;
    int         since = 0;
    bit         have_prev = 0;
    int         stall_left = 0;
    int         mw_run = 0;

    function automatic logic [13:0] exp_out(input string ph, input bit r);
        logic ir, pc, br, rw, mw, adr;
        logic [1:0] rs, a, b, al;
        ir = 0; pc = 0; br = 0; rw = 0; mw = 0; adr = 0;
        rs = 0; a = 0; b = 0; al = 0;
        case (ph)
            "F":    begin ir = r; pc = r; b = 2; rs = 2; end
            "D":    begin a = 1; b = 1; end
            "MADR": begin a = 2; b = 1; end
            "MRD":  begin adr = 1; end
            "MWB":  begin rs = 1; rw = 1; end
            "MWR":  begin adr = 1; mw = 1; end
            "EXR":  begin a = 2; al = 2; end
            "EXI":  begin a = 2; b = 1; al = 2; end
            "LUI":  begin b = 1; al = 3; end
            "WB":   begin rw = 1; end
            "JADR": begin a = 2; b = 1; end
            "JAL":  begin a = 1; b = 2; pc = 1; end
            "BEQ":  begin a = 2; al = 1; br = 1; end
            default: ;
        endcase
        return {ir, pc, br, rw, mw, adr, rs, a, b, al};
    endfunction

    task automatic mkplan(input logic [6:0] o);
        case (o)
            7'b0000011: q = '{"F", "D", "MADR", "MRD", "MWB"};
            7'b0100011: q = '{"F", "D", "MADR", "MWR"};
            7'b0110011: q = '{"F", "D", "EXR", "WB"};
            7'b0010011: q = '{"F", "D", "EXI", "WB"};
            7'b0110111: q = '{"F", "D", "LUI", "WB"};
            7'b0010111: q = '{"F", "D", "WB"};
            7'b1101111: q = '{"F", "D", "JAL", "WB"};
            7'b1100111: q = '{"F", "D", "JADR", "JAL", "WB"};
            7'b1100011: q = '{"F", "D", "BEQ"};
`ifdef ILLEGAL_TRAP_EN
            default:    q = '{"F", "D", "TRAP"};
`else
            default:    q = '{"F", "D"};
`endif
        endcase
    endtask

    function automatic int base_cpi(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b1100111: return 5;
            7'b0100011, 7'b0110011, 7'b0010011,
            7'b0110111, 7'b1101111: return 4;
            7'b1100011, 7'b0010111: return 3;
            default:                return 2;
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] t [9];
        int k;
        t = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        k = $urandom_range(0, 9);
`ifdef ILLEGAL_TRAP_EN
        if (k == 9) k = $urandom_range(0, 8);
`else
        if (k == 9) return 7'($urandom_range(0, 127));
`endif
        return t[k];
    endfunction

    // mode 0: ready high, 1: random ready, 2: stall MEMWRITE stall_left cycles
    task automatic step(input int mode, input bit rs);
        bit rdy;
        @(negedge clk);
        if (!rs && q.size() == 0) begin
            cur_op = (opq.size() != 0) ? opq.pop_front() : rand_op();
            mkplan(cur_op);
            cur_fw = 0;
            cur_nfw = 0;
        end
        rdy = 1'b1;
        if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        if (mode == 2 && !rs && q.size() != 0 && q[0] == "MWR" && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end
        op = cur_op;
        mem_ready = rdy;
        rst = rs;
        #1;
        chk("outs", 32'(outs), rs ? 32'(exp_out("F", 0)) : 32'(exp_out(q[0], rdy)));
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_instr", 32'(illegal_instr), 32'(m_ill));
`endif
        if (mem_write) mw_run++;
        if (rs) begin
            q.delete();
            m_ill = 0;
            have_prev = 0;
        end else begin
            since++;
            if (ir_write) begin
                if (have_prev) chk("cpi", since, done_base + done_nfw + cur_fw);
                have_prev = 1;
                since = 0;
            end
            if (!rdy && (q[0] == "F" || q[0] == "MRD" || q[0] == "MWR")) begin
                if (q[0] == "F") cur_fw++;
                else cur_nfw++;
            end else if (q[0] != "TRAP") begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    done_base = base_cpi(cur_op);
                    done_nfw = cur_nfw;
                end else if (q[0] == "TRAP") begin
                    m_ill = 1;
                end
            end
        end
    endtask

    task automatic run_all(input int mode);
        int n;
        n = 0;
        do begin
            step(mode, 0);
            n++;
        end while ((opq.size() != 0 || q.size() != 0) && n < 1000);
        if (n >= 1000) chk("run_bound", 32'(n), 32'd0);
    endtask

    initial begin
        step(0, 1);
        step(0, 1);

        opq = '{7'b0000011, 7'b0100011, 7'b1100111, 7'b1100011, 7'b0010111,
                7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111};
        run_all(0);

        opq.push_back(7'b0100011);
        stall_left = 3;
        mw_run = 0;
        run_all(2);
        chk("sw_mem_write_run", 32'(mw_run), 32'd4);

        for (int n = 0; n < 3000; n++)
            step(1, ($urandom_range(0, 49) == 0));
        run_all(1);

        opq.push_back(7'b1111111);
`ifdef ILLEGAL_TRAP_EN
        repeat (14) step(0, 0);
        step(0, 1);
        repeat (4) step(0, 0);
        run_all(0);
`else
        run_all(0);
        opq.push_back(7'b0110011);
        run_all(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
